wb_port_arbiter: RTL
====================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter STARVE_MAX, default 4, maximum consecutive cycles a pending MDU result waits before it takes priority.
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock domain.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pipe_we  input  1  pipeline writeback write request (W stage RegWrite).
REQ-006 SHALL have port pipe_rd  input  5  pipeline writeback destination register.
REQ-007 SHALL have port pipe_data  input  XLEN  pipeline writeback result.
REQ-008 SHALL have port mdu_valid  input  1  multi-cycle MUL/DIV result valid.
REQ-009 SHALL have port mdu_rd  input  5  MDU destination register.
REQ-010 SHALL have port mdu_data  input  XLEN  MDU result.
REQ-011 SHALL have port mdu_ready  output  1  arbiter can accept an MDU result this cycle.
REQ-012 SHALL have port rf_we  output  1  register file write enable (drives RegWriteW).
REQ-013 SHALL have port rf_rd  output  5  register file write address (drives RdW).
REQ-014 SHALL have port rf_wd  output  XLEN  register file write data (drives ResultW).
REQ-015 SHALL have port stall_wb  output  1  pipeline W stage must hold its write; the write is retried next cycle.
REQ-016 SHALL have port pending_mask  output  32  bit i set while an accepted MDU result for register i is not yet written; goes to the hazard unit.

Function
REQ-017 SHALL buffer MDU results in a 2-entry FIFO (rd, data) with separate read/write pointers and an occupancy count of 0..2.
REQ-018 SHALL drive mdu_ready = (count < 2), computed from registered state only; no combinational path from mdu_valid.
REQ-019 SHALL accept an MDU result on mdu_valid && mdu_ready; when mdu_rd == 0 it SHALL accept and discard it without a push.
REQ-020 SHALL treat a pipe request as live only when pipe_we && pipe_rd != 0; a pipe write to x0 is never granted to the register file.
REQ-021 SHALL select the grant each cycle, combinationally:
- force = FIFO non-empty && starve_cnt == STARVE_MAX.
- force: pop the FIFO head; stall_wb = live pipe request.
- else live pipe request: write pipe_rd/pipe_data; stall_wb = 0.
- else FIFO non-empty: pop the FIFO head.
- else rf_we = 0.
REQ-022 SHALL drive rf_rd and rf_wd to 0 whenever rf_we = 0.
REQ-023 SHALL let an accepted MDU result be written no earlier than the cycle after acceptance; there is no bypass from mdu_* to rf_*.
REQ-024 SHALL allow a push and a pop in the same cycle; count is unchanged and FIFO order is preserved.
REQ-025 SHALL keep starve_cnt (width clog2(STARVE_MAX+1)):
- cleared on a pop or when the FIFO is empty.
- incremented when the FIFO is non-empty and not popped.
- saturates at STARVE_MAX.
REQ-026 SHALL set bit rd in pending_mask on push and clear it on pop of that entry. Pending_mask is computed from valid FIFO entries, so two entries with the same rd keep the bit set until both are popped.
REQ-027 SHALL NOT reorder MDU results; head-of-line order equals acceptance order.
REQ-028 SHALL leave WAW ordering between pipe and MDU results to the hazard unit, which uses pending_mask; the arbiter performs no rd comparison between sources.

Reset
REQ-029 SHALL on reset clear both pointers, count, starve_cnt and the FIFO valid bits. During and after reset: mdu_ready = 1, rf_we = 0, rf_rd = 0, rf_wd = 0, stall_wb = 0, pending_mask = 0.
REQ-030 SHALL discard any buffered MDU result when reset is asserted mid-operation; no write for it occurs after reset.
REQ-031 SHALL take reset priority over push, pop and counter updates in the same cycle.

Verification
REQ-032 Idle pipe, mdu_valid=1, rd=5, data=0xDEADBEEF in cycle 0 -> cycle 1 rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF; pending_mask bit5 = 1 in cycle 1 only.
REQ-033 Two MDU pushes (rd=3, rd=4) back-to-back with pipe_we=1 and rd=7 every cycle -> mdu_ready=0 after the second push. STARVE_MAX cycles of pipe grants, then stall_wb=1 with rf_rd=3. Next cycle pipe (rd=7) is granted and starve_cnt restarts. rd=4 is forced STARVE_MAX pipe grants later.
REQ-034 FIFO full, simultaneous pop (pipe idle) and mdu_valid -> mdu_ready=0, so no push occurs; push is accepted the next cycle; order is preserved.
REQ-035 mdu_valid with rd=0, and pipe_we with rd=0 -> no rf_we, pending_mask stays 0, mdu_ready stays 1.
REQ-036 Reset asserted with 2 entries buffered -> next cycle count=0, pending_mask=0, rf_we=0; no stale write after reset deasserts.
REQ-037 Random pipe/MDU traffic against a scoreboard model -> every accepted nonzero-rd result is written exactly once, in order. No cycle has more than one write. stall_wb is asserted only when a live pipe request is blocked.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Writeback bus between the W stage, the multi-cycle MUL/DIV unit and the register file.
// The master side drives the requests; the arbiter is the slave and drives the register-file port.
interface wb_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            pipe_we;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            mdu_valid;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic            mdu_ready;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic            stall_wb;
  logic [31:0]     pending_mask;

  modport master (
    output pipe_we, pipe_rd, pipe_data, mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready, rf_we, rf_rd, rf_wd, stall_wb, pending_mask
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_data, mdu_valid, mdu_rd, mdu_data,
    output mdu_ready, rf_we, rf_rd, rf_wd, stall_wb, pending_mask
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline W stage and buffered MDU results.
// The pipeline normally wins; an MDU result that has waited STARVE_MAX cycles is forced through.
module wb_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               reset,
  wb_port_arbiter_if.slave  bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [4:0]      rd_q   [2];
  logic [XLEN-1:0] data_q [2];
  logic [1:0]      valid_q;
  logic            wptr;
  logic            rptr;
  logic [1:0]      count;
  logic [SW-1:0]   starve_cnt;

  logic            nonempty;
  logic            live_pipe;
  logic            force_mdu;
  logic            pop;
  logic            push;
  logic            rf_we_int;
  logic [31:0]     mask;

  // Grant selection; reset gates every output so nothing leaks out while state is being cleared.
  always_comb begin
    nonempty  = (count != 2'd0);
    live_pipe = bus.pipe_we && (bus.pipe_rd != 5'd0);
    force_mdu = nonempty && (starve_cnt == STARVE_LIM);
    pop       = !reset && nonempty && (force_mdu || !live_pipe);
    push      = !reset && bus.mdu_valid && (count < 2'd2) && (bus.mdu_rd != 5'd0);
    rf_we_int = !reset && (pop || live_pipe);
  end

  always_comb begin
    mask = 32'd0;
    for (int i = 0; i < 2; i++) begin
      if (valid_q[i]) begin
        mask[rd_q[i]] = 1'b1;
      end
    end
  end

  assign bus.mdu_ready    = reset || (count < 2'd2);
  assign bus.rf_we        = rf_we_int;
  assign bus.rf_rd        = pop ? rd_q[rptr]   : (rf_we_int ? bus.pipe_rd   : 5'd0);
  assign bus.rf_wd        = pop ? data_q[rptr] : (rf_we_int ? bus.pipe_data : '0);
  assign bus.stall_wb     = !reset && force_mdu && live_pipe;
  assign bus.pending_mask = reset ? 32'd0 : mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      count      <= 2'd0;
      starve_cnt <= '0;
      valid_q    <= 2'b00;
    end else begin
      // Push and pop never target the same slot: that would need count 0 or 2.
      if (push) begin
        valid_q[wptr] <= 1'b1;
        wptr          <= ~wptr;
      end
      if (pop) begin
        valid_q[rptr] <= 1'b0;
        rptr          <= ~rptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop || !nonempty) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr]   <= bus.mdu_rd;
      data_q[wptr] <= bus.mdu_data;
    end
  end
endmodule
